// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that reuses one 4-bit carry-lookahead slice, one nibble per clock.
// Subtract mode (sub port, A - B) is built only when SERIAL_SUB_EN is defined.

module cla_dataflow (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Every carry is flattened to a two-level sum of products of g, p and cin.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NNIB = WIDTH / 4;
    localparam int IDXW = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NNIB - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [IDXW-1:0]  idx_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             sub_mode;
    logic             start_carry;
    logic             accept;

`ifdef SERIAL_SUB_EN
    logic sub_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sub_reg <= 1'b0;
        end else if (accept) begin
            sub_reg <= sub;
        end
    end

    assign sub_mode    = sub_reg;
    // Two's-complement subtract: invert B and inject the +1 as the first carry.
    assign start_carry = sub ? 1'b1 : cin;
`else
    assign sub_mode    = 1'b0;
    assign start_carry = cin;
`endif

    logic [3:0] a_nib [NNIB];
    logic [3:0] b_nib [NNIB];

    generate
        for (genvar gi = 0; gi < NNIB; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[4*gi +: 4];
            assign b_nib[gi] = b_reg[4*gi +: 4] ^ {4{sub_mode}};
        end
    endgenerate

    logic [3:0] slice_sum;
    logic       slice_cout;

    cla_dataflow u_slice (
        .a    (a_nib[idx_reg]),
        .b    (b_nib[idx_reg]),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign accept = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    carry_reg <= slice_cout;
                    idx_reg   <= idx_reg + 1'b1;
                    for (int i = 0; i < NNIB; i++) begin
                        if (idx_reg == IDXW'(i)) begin
                            sum_reg[4*i +: 4] <= slice_sum;
                        end
                    end
                    if (idx_reg == LAST_IDX) begin
                        cout_reg  <= slice_cout;
                        state_reg <= ST_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; DONE lasts one cycle.
                    if (accept) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= start_carry;
                        idx_reg   <= '0;
                        state_reg <= ST_RUN;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state_reg == ST_RUN);
    assign done = (state_reg == ST_DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: expected results come from plain-arithmetic A+B+CIN (or A-B).
// Define SERIAL_SUB_EN for both bench and RTL to exercise the subtract mode.

module tb_nibble_serial_adder;
    localparam int WIDTH = 16;
    localparam int NNIB  = WIDTH / 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests        = 0;
    int   fails        = 0;
    int   done_count   = 0;
    int   busy_len     = 0;
    int   cyc          = 0;
    int   last_done_cyc = -1;
    bit   abort        = 1'b0;
    bit   b2b_mode     = 1'b0;
    logic prev_done    = 1'b0;

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci, input logic s);
        exp_t e;
        longint unsigned t;
        if (s) begin
            e.sum  = x - y;
            e.cout = (x >= y);
        end else begin
            t      = longint'(x) + longint'(y) + longint'(ci);
            e.sum  = t[WIDTH-1:0];
            e.cout = t[WIDTH];
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Called at a negedge: presents one request for a single cycle.
    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic ci, input logic s);
        a   = x;
        b   = y;
        cin = ci;
`ifdef SERIAL_SUB_EN
        sub = s;
`endif
        start = 1'b1;
        exp_q.push_back(model(x, y, ci, s));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: pops one expectation per DONE pulse and checks BUSY run length.
    always @(negedge clk) begin
        if (busy) begin
            busy_len++;
        end else if (busy_len > 0) begin
            if (abort) begin
                abort = 1'b0;
            end else begin
                tests++;
                if (busy_len != NNIB) begin
                    fails++;
                    $display("FAIL busy_len: got %0d cycles, required %0d", busy_len, NNIB);
                end
            end
            busy_len = 0;
        end
        if (done) begin
            done_count++;
            tests++;
            if (prev_done) begin
                fails++;
                $display("FAIL done_pulse: done high %0d consecutive cycles, required 1", 2);
            end
            if (b2b_mode && last_done_cyc >= 0) begin
                tests++;
                if (cyc - last_done_cyc != NNIB + 1) begin
                    fails++;
                    $display("FAIL b2b_interval: got %0d cycles, required %0d", cyc - last_done_cyc, NNIB + 1);
                end
            end
            last_done_cyc = cyc;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: sum=%h cout=%b, required no DONE", sum, cout);
            end else begin
                mon_e = exp_q.pop_front();
                if (sum !== mon_e.sum || cout !== mon_e.cout) begin
                    fails++;
                    $display("FAIL result: sum=%h cout=%b, required sum=%h cout=%b",
                             sum, cout, mon_e.sum, mon_e.cout);
                end else begin
                    $display("[TB] result #%0d sum=%h cout=%b matches", done_count, sum, cout);
                end
            end
        end
        prev_done = done;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic ci;
        logic s;

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
`ifdef SERIAL_SUB_EN
        sub   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_state", 64'({sum, cout, busy, done}), 64'd0);

        // Directed addition and latency
        issue(16'h1234, 16'h1111, 1'b0, 1'b0);
        check("t1_busy_first", 64'({busy, done}), 64'b10);
        repeat (NNIB - 1) @(negedge clk);
        check("t1_busy_last", 64'({busy, done}), 64'b10);
        @(negedge clk);
        check("t1_done", 64'({busy, done}), 64'b01);
        @(negedge clk);
        check("t1_done_drop", 64'(done), 64'd0);
        check("t1_sum_held", 64'({sum, cout}), 64'({16'h2345, 1'b0}));

        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        drain();
        issue(16'h0000, 16'h0000, 1'b1, 1'b0);
        drain();

        // START during RUN is ignored
        snap = done_count;
        issue(16'h0102, 16'h0304, 1'b0, 1'b0);
        a     = 16'hBEEF;
        b     = 16'hCAFE;
        cin   = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        drain();
        repeat (8) @(negedge clk);
        check("t3_ignored_start", 64'(done_count - snap), 64'd1);

        // START held high: back-to-back operations every NNIB+1 cycles
        b2b_mode      = 1'b1;
        last_done_cyc = -1;
        start         = 1'b1;
        for (int k = 0; k < 3; k++) begin
            x  = WIDTH'($urandom);
            y  = WIDTH'($urandom);
            ci = 1'($urandom_range(0, 1));
            a   = x;
            b   = y;
            cin = ci;
`ifdef SERIAL_SUB_EN
            sub = 1'b0;
`endif
            exp_q.push_back(model(x, y, ci, 1'b0));
            for (int j = 0; j < NNIB + 1; j++) begin
                @(negedge clk);
                a   = WIDTH'($urandom);
                b   = WIDTH'($urandom);
                cin = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
        drain();
        b2b_mode = 1'b0;

        // Reset in the middle of RUN aborts without DONE
        issue(16'hABCD, 16'h1234, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        abort = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("t4_reset_outputs", 64'({sum, cout, busy, done}), 64'd0);
        reset = 1'b0;
        snap  = done_count;
        repeat (8) @(negedge clk);
        check("t4_no_done", 64'(done_count - snap), 64'd0);
        issue(16'h0F0F, 16'h00F1, 1'b1, 1'b0);
        drain();

`ifdef SERIAL_SUB_EN
        issue(16'h0005, 16'h0007, 1'b0, 1'b1);
        drain();
        issue(16'h0007, 16'h0005, 1'b0, 1'b1);
        drain();
        issue(16'h0007, 16'h0005, 1'b1, 1'b1);
        drain();
`endif

        // Random sweep
        for (int n = 0; n < 40; n++) begin
            x  = WIDTH'($urandom);
            y  = WIDTH'($urandom);
            ci = 1'($urandom_range(0, 1));
`ifdef SERIAL_SUB_EN
            s  = 1'($urandom_range(0, 1));
`else
            s  = 1'b0;
`endif
            issue(x, y, ci, s);
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
